if_prefetch_queue: RTL and testbench

//  Instruction-fetch prefetch stage between the instruction SRAM wrapper (IM1) and cpu decode.

---
 rtl/if_prefetch_queue.sv | 105 ++++++++++
 tb/tb_if_prefetch_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch stage: issues sequential word addresses to the
// instruction SRAM, captures its 1-cycle-latency read data and presents
// {pc, inst} pairs to decode through a small FIFO with valid/ready handshake.
// A redirect flushes everything (queue and outstanding read) and restarts fetch.
module if_prefetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [DATA_W-1:0] isram_dataout,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data,
  input  logic              inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [CNT_W:0]    occupancy;
  logic              issue_en;
  logic              push;
  logic              pop;

  // Issue only when a FIFO slot is reserved for the word; this reservation is
  // what guarantees a capture never finds the FIFO full.
  always_comb begin
    occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
    issue_en   = !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
    push       = inflight && !redirect_valid;
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready && !redirect_valid;
    isram_addr = fetch_pc;
    inst_pc    = pc_mem[rd_ptr];
    inst_data  = data_mem[rd_ptr];
  end

  // Fetch pointer and the single outstanding-read tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight    <= 1'b0;
    end else if (issue_en) begin
      fetch_pc    <= fetch_pc + ADDR_W'(4);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= inflight_pc;
      data_mem[wr_ptr] <= isram_dataout;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: a queue-based reference model of
// the fetch stream is compared against the DUT outputs every cycle.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] isram_addr;
  logic [31:0] isram_dataout;
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  if_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .isram_addr     (isram_addr),
    .isram_dataout  (isram_dataout),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return 32'h1000_0000 + {18'h0, a[15:2]};
  endfunction

  // instruction SRAM: word for the address sampled at the previous edge
  always @(posedge clk) isram_dataout <= word_at(isram_addr);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: expected queue contents, pending read and next fetch pc
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          pend;
  logic [15:0] pend_pc;
  logic [15:0] m_pc;

  task automatic model_reset();
    q.delete();
    pend = 0;
    pend_pc = '0;
    m_pc = 16'h0000;
  endtask

  // advance the model across one rising edge using the driven inputs
  task automatic model_edge();
    int occ;
    bit p;
    if (redirect_valid) begin
      q.delete();
      pend = 0;
      m_pc = {redirect_pc[15:2], 2'b00};
    end else begin
      occ = q.size();
      p   = pend;
      if (occ != 0 && inst_ready) void'(q.pop_front());
      if (p) q.push_back('{pc: pend_pc, data: word_at(pend_pc)});
      if (occ + int'(p) < DEPTH) begin
        pend    = 1;
        pend_pc = m_pc;
        m_pc    = m_pc + 16'd4;
      end else begin
        pend = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_val("inst_valid", inst_valid, q.size() != 0);
    check_val("isram_addr", isram_addr, m_pc);
    if (q.size() != 0) begin
      check_val("inst_pc", inst_pc, q[0].pc);
      check_val("inst_data", inst_data, q[0].data);
    end
  endtask

  int ready_mode;

  task automatic drive_random(input int cyc);
    int r;
    if (cyc % 40 == 0) ready_mode = $urandom_range(0, 2);
    case (ready_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = 1'b0;
      default: inst_ready = $urandom_range(0, 1);
    endcase
    redirect_valid = ($urandom_range(0, 24) == 0);
    r = $urandom_range(0, 3);
    case (r)
      0:       redirect_pc = 16'hFFF8;
      1:       redirect_pc = 16'h0102;
      default: redirect_pc = 16'($urandom);
    endcase
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_valid", inst_valid, 1'b0);
    check_val("rst_pc", inst_pc, 16'h0);
    check_val("rst_data", inst_data, 32'h0);
    check_val("rst_addr", isram_addr, 16'h0);

    // fill with decode stalled: four entries, fetch stops at 0x0010
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      compare_outputs();
      model_edge();
      @(negedge clk);
    end
    check_val("fill_hold_addr", isram_addr, 16'h0010);
    check_val("fill_head_pc", inst_pc, 16'h0000);
    check_val("fill_head_data", inst_data, 32'h1000_0000);

    // drain and stream, then random traffic with redirects
    inst_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      compare_outputs();
      model_edge();
      @(negedge clk);
    end

    for (int c = 0; c < 3000; c++) begin
      compare_outputs();
      drive_random(c);
      model_edge();
      if (c == 1500) begin
        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_valid", inst_valid, 1'b0);
        check_val("arst_pc", inst_pc, 16'h0);
        check_val("arst_data", inst_data, 32'h0);
        check_val("arst_addr", isram_addr, 16'h0);
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
      end else begin
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
